line_buffer_window3x3: RTL and testbench
========================================

# line_buffer_window3x3

Parametrised successor to the fixed double line buffer. Accepts a raster-order pixel stream of configurable width and image size. Stores the two previous lines in on-chip line memories and emits a fully registered 3x3 neighbourhood window with a window-valid strobe, the centre coordinates and an end-of-frame pulse. It sits between the pixel source and the Sobel/edge kernel, which consumes one window per `valid_o`.

## Interface
- `DATA_W`, default 8: pixel width in bits.
- `IMG_W`, default 640: pixels per line, at least 3.
- `IMG_H`, default 480: lines per frame, at least 3.
- `CW`, default `$clog2(IMG_W)`: column counter width (derived, not overridden).
- `RW`, default `$clog2(IMG_H)`: row counter width (derived, not overridden).

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: reset is synchronous and active-low.
- `we_i` in 1: pixel write strobe; one pixel is accepted per cycle when high.
- `data_i` in `DATA_W`: pixel value, sampled when `we_i`=1.
- `win_o` out `9*DATA_W`: packed window. `win_o[DATA_W*(3*i+j) +: DATA_W]` holds window row i (0 = oldest line, top) and column j (0 = leftmost, oldest).
- `valid_o` out 1: `win_o` holds a complete window; one-cycle strobe.
- `cx_o` out `CW`: column of the window centre.
- `cy_o` out `RW`: row of the window centre.
- `done_o` out 1: one-cycle pulse after the last pixel of a frame.

## Operation
- **Counters:** column counter `c` and row counter `r` give the position of the pixel being accepted. Both advance only when `we_i`=1.
  - `c` wraps from IMG_W-1 to 0, and `r` increments on that wrap.
  - `r` wraps from IMG_H-1 to 0, and the next frame starts immediately.
- **Line memories:** two memories of depth IMG_W, L0 and L1. For an accepted pixel at column c:
  - Vertical taps are top=L1[c] (row r-2), mid=L0[c] (row r-1), bottom=`data_i` (row r).
  - In the same cycle, L1[c]<=L0[c] and L0[c]<=`data_i`. This is read-before-write; the old values feed the taps.
- **Window registers:** a 3x3 register array shifts left by one column on each accepted pixel. The new column {top, mid, bottom} enters at j=2. The array holds its value when `we_i`=0. `win_o` is driven directly from this array.
- **Window validity:** the window is complete when the accepted pixel has r>=2 and c>=2. In that case, next cycle:
  - `valid_o`=1
  - `cx_o`=c-1
  - `cy_o`=r-1
- Windows that straddle a line wrap (c<2) or the top of a frame (r<2) are never flagged valid, so there is no border padding. Stale line-memory contents from a previous frame are masked by the same r>=2 rule.
- **Frame end:** accepting the pixel at (IMG_W-1, IMG_H-1) pulses `done_o` next cycle. That pixel also produces the frame's last valid window, so `valid_o` and `done_o` are high in the same cycle.
- **Frame count:** valid windows per frame = (IMG_W-2)*(IMG_H-2).
- **Reset mid-frame:** counters return to (0,0) and the partial frame is discarded. The next accepted pixel is treated as (0,0) of a new frame. Line memories are not cleared.

## Timing
- **Reset values** (after a cycle with `rst`=0): all of these are 0, and so are `c`, `r` and the window array.
  - `win_o`
  - `valid_o`
  - `done_o`
  - `cx_o`
  - `cy_o`
- **Latency:** 1 cycle from the accepted `we_i` edge to `valid_o`, `win_o`, `cx_o`, `cy_o` and `done_o`. All outputs are registered.
- **Strobes:** `valid_o` and `done_o` are low in any cycle following `we_i`=0. `win_o`, `cx_o` and `cy_o` hold their last values.
- **Back-pressure:** none; the consumer must take a window in its valid cycle. Gaps in `we_i` of any length are allowed.
- **Throughput:** one pixel per cycle sustained, with no bubbles at line or frame wrap.
- **Reset priority:** `rst`=0 has priority over `we_i` in the same cycle, and that pixel is dropped.

## Test plan
- **Basic frame:** IMG_W=5, IMG_H=3, DATA_W=8. Feed pixels 0..14 back-to-back.
  - Exactly 3 `valid_o` cycles, on the cycles after pixels 12, 13 and 14.
  - First window is {0,1,2 / 5,6,7 / 10,11,12} with `cx_o`=1, `cy_o`=1.
  - Last window is {2,3,4 / 7,8,9 / 12,13,14} with `cx_o`=3, `cy_o`=1.
  - `done_o` is high only with the third valid.
- **Gapped stream:** same stream with `we_i` dropped for 1–3 random cycles between pixels. The window sequence is identical to the basic frame, and `valid_o` is never high after a `we_i`=0 cycle.
- **Back-to-back frames:** feed 0..14 then 100..114 with no gap.
  - No `valid_o` during 100..111.
  - The second-frame first window is {100,101,102 / 105,106,107 / 110,111,112}.
  - Two `done_o` pulses in total.
- **Reset mid-frame:** feed 0..6, hold `rst`=0 for 1 cycle, then feed 100..114.
  - All outputs are 0 the cycle after reset.
  - The results match the second frame of the back-to-back test.
- **Parameter sweep:** DATA_W=10, IMG_W=8, IMG_H=4, pixel value = 1000-index.
  - 12 valids, and window values match a reference model at bit width 10.
  - `cx_o` covers 1..6 and `cy_o` covers 1..2.
  - One `done_o` pulse.

Source files
------------

// File: rtl/line_buffer_window3x3.sv
// line_buffer_window3x3: two-line buffer feeding a registered 3x3 window with centre coordinates and frame-end pulse
module line_buffer_window3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW = $clog2(IMG_W),
  parameter int RW = $clog2(IMG_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic [9*DATA_W-1:0]   win_o,
  output logic                  valid_o,
  output logic [CW-1:0]         cx_o,
  output logic [RW-1:0]         cy_o,
  output logic                  done_o
);
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic [DATA_W-1:0] l0 [IMG_W];
  logic [DATA_W-1:0] l1 [IMG_W];
  logic [DATA_W-1:0] w [3][3];
  logic [DATA_W-1:0] col [3];
  logic last_c, last_r, full, acc;
  always_comb begin
    acc = we_i & rst;
    last_c = c == CW'(IMG_W - 1);
    last_r = r == RW'(IMG_H - 1);
    full = r >= RW'(2) && c >= CW'(2);
    col[0] = l1[c];
    col[1] = l0[c];
    col[2] = data_i;
  end
  // line memories are never cleared; stale rows are masked by the r>=2 rule
  always_ff @(posedge clk) begin
    if (acc) begin
      l1[c] <= l0[c];
      l0[c] <= data_i;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      c <= '0;
      r <= '0;
      valid_o <= 1'b0;
      done_o <= 1'b0;
      cx_o <= '0;
      cy_o <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[i][j] <= '0;
    end else begin
      valid_o <= we_i && full;
      done_o <= we_i && last_c && last_r;
      if (we_i) begin
        c <= last_c ? '0 : c + CW'(1);
        if (last_c) r <= last_r ? '0 : r + RW'(1);
        for (int i = 0; i < 3; i++) begin
          w[i][0] <= w[i][1];
          w[i][1] <= w[i][2];
          w[i][2] <= col[i];
        end
        if (full) begin
          cx_o <= c - CW'(1);
          cy_o <= r - RW'(1);
        end
      end
    end
  end
  for (genvar i = 0; i < 3; i++) begin : g_row
    for (genvar j = 0; j < 3; j++) begin : g_col
      assign win_o[DATA_W*(3*i+j) +: DATA_W] = w[i][j];
    end
  end
endmodule

// File: tb/tb_line_buffer_window3x3.sv
// tb_line_buffer_window3x3: scoreboard bench; a frame-store model predicts every window for a small and a wide instance
module tb_line_buffer_window3x3;
  typedef struct {
    logic [89:0] win;
    int cx;
    int cy;
    bit done;
  } ent_t;
  logic clk = 1'b0, rst = 1'b0;
  logic we_a = 1'b0, we_b = 1'b0;
  logic [7:0] data_a = '0;
  logic [9:0] data_b = '0;
  logic [71:0] win_a;
  logic [89:0] win_b, wa;
  logic valid_a, valid_b, done_a, done_b, pwa, pwb;
  logic [2:0] cx_a, cx_b;
  logic [1:0] cy_a, cy_b;
  ent_t qa[$], qb[$];
  int img [2][8][8];
  int pc[2] = '{0, 0}, pr[2] = '{0, 0};
  int iw[2] = '{5, 8}, ih[2] = '{3, 4};
  int got_v[2] = '{0, 0}, got_d[2] = '{0, 0};
  int n_tests = 0, n_fail = 0;

  line_buffer_window3x3 #(.DATA_W(8), .IMG_W(5), .IMG_H(3)) dut_a (
    .clk(clk), .rst(rst), .we_i(we_a), .data_i(data_a), .win_o(win_a),
    .valid_o(valid_a), .cx_o(cx_a), .cy_o(cy_a), .done_o(done_a));
  line_buffer_window3x3 #(.DATA_W(10), .IMG_W(8), .IMG_H(4)) dut_b (
    .clk(clk), .rst(rst), .we_i(we_b), .data_i(data_b), .win_o(win_b),
    .valid_o(valid_b), .cx_o(cx_b), .cy_o(cy_b), .done_o(done_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [89:0] got, input logic [89:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pix(input int d, input int v);
    ent_t e;
    @(negedge clk);
    we_a = d == 0;
    we_b = d == 1;
    data_a = 8'(v);
    data_b = 10'(v);
    img[d][pr[d]][pc[d]] = v;
    if (pr[d] >= 2 && pc[d] >= 2) begin
      e.win = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.win[10*(3*i+j) +: 10] = 10'(img[d][pr[d]-2+i][pc[d]-2+j]);
      e.cx = pc[d] - 1;
      e.cy = pr[d] - 1;
      e.done = pc[d] == iw[d] - 1 && pr[d] == ih[d] - 1;
      if (d == 0) qa.push_back(e);
      else qb.push_back(e);
    end
    if (pc[d] == iw[d] - 1) begin
      pc[d] = 0;
      pr[d] = pr[d] == ih[d] - 1 ? 0 : pr[d] + 1;
    end else pc[d]++;
  endtask

  task automatic idle();
    @(negedge clk);
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  task automatic mon(input int d, input logic v, input logic dn, input logic [89:0] w,
                     input int cx, input int cy, input logic pw);
    ent_t e;
    bit empty;
    if ((v || dn) && !pw) chk("strobe_after_gap", 90'({v, dn}), 90'(0));
    if (dn && !v) chk("done_without_valid", 90'(v), 90'(1));
    if (dn) got_d[d]++;
    if (v) begin
      got_v[d]++;
      empty = d == 0 ? qa.size() == 0 : qb.size() == 0;
      if (empty) chk("spurious_valid", 90'(v), 90'(0));
      else begin
        if (d == 0) e = qa.pop_front();
        else e = qb.pop_front();
        chk(d == 0 ? "win_a" : "win_b", w, e.win);
        chk("cx", 90'(cx), 90'(e.cx));
        chk("cy", 90'(cy), 90'(e.cy));
        chk("done", 90'(dn), 90'(e.done));
      end
    end
  endtask

  always @(posedge clk) begin
    pwa = we_a;
    pwb = we_b;
    #1;
    wa = '0;
    for (int k = 0; k < 9; k++) wa[10*k +: 10] = {2'b00, win_a[8*k +: 8]};
    mon(0, valid_a, done_a, wa, int'(cx_a), int'(cy_a), pwa);
    mon(1, valid_b, done_b, win_b, int'(cx_b), int'(cy_b), pwb);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_win_a", 90'(win_a), 90'(0));
    chk("rst_valid_a", 90'(valid_a), 90'(0));
    chk("rst_done_a", 90'(done_a), 90'(0));
    chk("rst_cx_a", 90'(cx_a), 90'(0));
    chk("rst_cy_a", 90'(cy_a), 90'(0));
    chk("rst_win_b", win_b, 90'(0));
    chk("rst_valid_b", 90'(valid_b), 90'(0));
    chk("rst_done_b", 90'(done_b), 90'(0));
    rst = 1'b1;
    for (int i = 0; i < 15; i++) pix(0, i);
    repeat (2) idle();
    for (int i = 0; i < 15; i++) begin
      pix(0, i);
      repeat ($urandom_range(1, 3)) idle();
    end
    for (int i = 0; i < 15; i++) pix(0, i);
    for (int i = 0; i < 15; i++) pix(0, 100 + i);
    idle();
    for (int i = 0; i < 7; i++) pix(0, i);
    // reset wins over a simultaneous write: 99 must be dropped
    @(negedge clk);
    rst = 1'b0;
    data_a = 8'd99;
    pc[0] = 0;
    pr[0] = 0;
    @(negedge clk);
    chk("mid_rst_win", 90'(win_a), 90'(0));
    chk("mid_rst_valid", 90'(valid_a), 90'(0));
    chk("mid_rst_done", 90'(done_a), 90'(0));
    chk("mid_rst_cx", 90'(cx_a), 90'(0));
    chk("mid_rst_cy", 90'(cy_a), 90'(0));
    rst = 1'b1;
    we_a = 1'b0;
    for (int i = 0; i < 15; i++) pix(0, 100 + i);
    idle();
    for (int i = 0; i < 32; i++) pix(1, 1000 - i);
    repeat (4) idle();
    chk("a_valid_total", 90'(got_v[0]), 90'(15));
    chk("a_done_total", 90'(got_d[0]), 90'(5));
    chk("b_valid_total", 90'(got_v[1]), 90'(12));
    chk("b_done_total", 90'(got_d[1]), 90'(1));
    chk("a_pending", 90'(qa.size()), 90'(0));
    chk("b_pending", 90'(qb.size()), 90'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
